cla_serial_wide_adder_ctrl: RTL and testbench

Nibble-serial controller that reuses one `Look_Ahead_Carry_Adder_4Bit` instance to add WIDTH-bit operands over WIDTH/4 clock cycles. The carry is held in a register between nibbles. The block sits between a requester using a start/busy/done handshake and the shared 4-bit CLA datapath. It trades latency for area wherever a wide adder is needed only occasionally.

---
 rtl/cla_serial_wide_adder_ctrl.sv | 151 +++++++++++++++
 tb/tb_cla_serial_wide_adder_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_serial_wide_adder_ctrl.sv
// Nibble-serial wide adder: one shared 4-bit CLA adds WIDTH-bit operands over WIDTH/4 cycles.
// Optional subtract mode is enabled by defining CLA_SERIAL_SUB_EN (adds the sub port).

module Look_Ahead_Carry_Adder_4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       Cin,
  output logic       Cout,
  output logic [3:0] Sum
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p    = a ^ b;
  assign g    = a & b;
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign Sum  = p ^ c[3:0];
  assign Cout = c[4];
endmodule

// state | meaning
// IDLE  | waiting for start; sum/cout hold last result
// ADD   | one nibble per cycle through the shared CLA, busy=1
// DONE  | one-cycle done pulse, then back to IDLE
module cla_serial_wide_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int N     = WIDTH / 4;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       cla_sum;
  logic             cla_cout;
  logic [WIDTH+3:0] sum_cat;

  Look_Ahead_Carry_Adder_4Bit u_cla (
    .a    (opa_q[3:0]),
    .b    (opb_q[3:0]),
    .Cin  (carry_q),
    .Cout (cla_cout),
    .Sum  (cla_sum)
  );

  // New nibble enters at the top; after N shifts the result is aligned.
  assign sum_cat = {cla_sum, sum_q};

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
`ifdef CLA_SERIAL_SUB_EN
          if (sub) begin
            opb_d   = ~b;
            carry_d = 1'b1;
          end
`endif
          sum_d   = '0;
          cout_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d   = sum_cat[WIDTH+3:4];
        opa_d   = opa_q >> 4;
        opb_d   = opb_q >> 4;
        carry_d = cla_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cout_d  = cla_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_ADD);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_cla_serial_wide_adder_ctrl.sv
// Self-checking bench for cla_serial_wide_adder_ctrl (WIDTH=16) using an expected-result queue.
// Subtract scenarios run only when CLA_SERIAL_SUB_EN is defined.

module tb_cla_serial_wide_adder_ctrl;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;
`ifdef CLA_SERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH:0] sb[$];

  cla_serial_wide_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef CLA_SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                           input logic tc, input logic ts);
    logic [WIDTH:0] r;
    if (ts && SUB_EN) r = {1'b0, ta} + {1'b0, ~tb_} + (WIDTH+1)'(1);
    else              r = {1'b0, ta} + {1'b0, tb_} + (WIDTH+1)'(tc);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge E0.
  task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic tc, input logic ts);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    sb.push_back(model(ta, tb_, tc, ts));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(output int busy_cycles, output bit got_done);
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== '0) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    @(negedge clk);
  endtask

  task automatic test_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tc, input logic ts);
    int bc;
    bit gd;
    logic [WIDTH:0] e;
    launch(ta, tb_, tc, ts);
    collect(bc, gd);
    e = (sb.size() > 0) ? sb.pop_front() : 'x;
    checks++; if (!gd) begin failures++; $display("FAIL %s_done got=timeout exp=pulse", name); end
    checks++; if (bc != N) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, bc, N); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_in_done got=%b exp=0", name, busy); end
    checks++; if (sum !== e[WIDTH-1:0]) begin failures++; $display("FAIL %s_sum got=%h exp=%h", name, sum, e[WIDTH-1:0]); end
    checks++; if (cout !== e[WIDTH]) begin failures++; $display("FAIL %s_cout got=%b exp=%b", name, cout, e[WIDTH]); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_done_width got=%b exp=0", name, done); end
    checks++; if (sum !== e[WIDTH-1:0]) begin failures++; $display("FAIL %s_sum_hold got=%h exp=%h", name, sum, e[WIDTH-1:0]); end
  endtask

  task automatic test_basic;
    test_op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0);
  endtask

  task automatic test_carry_chain;
    test_op("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_start;
    int dones = 0;
    logic [WIDTH-1:0] s_at = '0;
    logic c_at = 1'b0;
    logic [WIDTH:0] e;
    launch(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        dones++;
        s_at = sum;
        c_at = cout;
      end
      @(negedge clk);
    end
    e = (sb.size() > 0) ? sb.pop_front() : 'x;
    checks++; if (dones != 1) begin failures++; $display("FAIL ignored_start_dones got=%0d exp=1", dones); end
    checks++; if (s_at !== e[WIDTH-1:0]) begin failures++; $display("FAIL ignored_start_sum got=%h exp=%h", s_at, e[WIDTH-1:0]); end
    checks++; if (c_at !== e[WIDTH]) begin failures++; $display("FAIL ignored_start_cout got=%b exp=%b", c_at, e[WIDTH]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignored_start_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    launch(16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (sb.size() > 0) void'(sb.pop_back());
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_mid_done got=%b exp=0", done); end
    checks++; if (sum !== '0) begin failures++; $display("FAIL reset_mid_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_mid_cout got=%b exp=0", cout); end
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL reset_mid_no_done got=%0d exp=0", dones); end
    test_op("after_reset", 16'h00FF, 16'h0001, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      test_op("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_sub;
    test_op("sub_no_borrow", 16'h1000, 16'h0001, 1'b0, 1'b1);
    test_op("sub_borrow", 16'h0000, 16'h0001, 1'b1, 1'b1);
    test_op("sub_mode_add", 16'h0F00, 16'h00F0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    int rises = 0;
    int dones = 0;
    int last_rise = -1;
    bit prev_busy = 1'b0;
    bit have_res = 1'b0;
    logic [WIDTH:0] last_res = '0;
    logic [WIDTH:0] e;
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        rises++;
        if (last_rise >= 0) begin
          checks++;
          if (i - last_rise != N + 2) begin
            failures++; $display("FAIL b2b_accept_gap got=%0d exp=%0d", i - last_rise, N + 2);
          end
        end
        last_rise = i;
        sb.push_back(model(16'h0F0F, 16'h0101, 1'b0, 1'b0));
      end
      if (done) begin
        dones++;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++; if ({cout, sum} !== e) begin failures++; $display("FAIL b2b_result got=%h exp=%h", {cout, sum}, e); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_in_done got=%b exp=0", busy); end
        have_res = 1'b1;
        last_res = e;
      end else if (!busy && have_res) begin
        checks++; if ({cout, sum} !== last_res) begin failures++; $display("FAIL b2b_hold got=%h exp=%h", {cout, sum}, last_res); end
      end
      prev_busy = busy;
    end
    start = 1'b0;
    checks++; if (rises != 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", rises); end
    checks++; if (dones != 3) begin failures++; $display("FAIL b2b_dones got=%0d exp=3", dones); end
    repeat (N + 3) @(negedge clk);
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_ignored_start();
    test_reset_mid();
    test_random();
`ifdef CLA_SERIAL_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
